// File: rtl/traffic_light_monitor.sv
// Conflict/sequence monitor for the four-approach light bus (M1, M2, MT, S).
// Latches the first violation as a sticky fault with code/source and counts completed S cycles.

module tlm_lamp_chk #(
    parameter int MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_cur,
    input  logic [2:0] i_prev,
    input  logic       i_prev_valid,
    output logic       o_enc_bad,
    output logic       o_non_red,
    output logic       o_seq_bad,
    output logic       o_short_y,
    output logic       o_y2r
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [3:0] MIN_Y = 4'(MIN_YELLOW);

    logic [3:0] r_dwell;
    logic       w_cur_ok;
    logic       w_prev_ok;
    logic       w_cmp;

    assign w_cur_ok  = (i_cur == RED) || (i_cur == YEL) || (i_cur == GRN);
    assign w_prev_ok = (i_prev == RED) || (i_prev == YEL) || (i_prev == GRN);
    // Transition checks only make sense between two well-encoded samples
    assign w_cmp     = i_prev_valid && w_cur_ok && w_prev_ok;

    assign o_enc_bad = !w_cur_ok;
    assign o_non_red = (i_cur != RED);
    assign o_seq_bad = w_cmp && (((i_prev == GRN) && (i_cur == RED)) ||
                                 ((i_prev == RED) && (i_cur == YEL)) ||
                                 ((i_prev == YEL) && (i_cur == GRN)));
    assign o_y2r     = w_cmp && (i_prev == YEL) && (i_cur == RED);
    assign o_short_y = o_y2r && (r_dwell < MIN_Y);

    // r_dwell holds the number of consecutive yellow samples seen so far
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= 4'd0;
        end else if (i_cur == YEL) begin
            if (i_prev_valid && (i_prev == YEL))
                r_dwell <= (r_dwell == 4'hF) ? r_dwell : r_dwell + 4'd1;
            else
                r_dwell <= 4'd1;
        end else begin
            r_dwell <= 4'd0;
        end
    end
endmodule

module traffic_light_monitor #(
    parameter int STALL_LIMIT = 12,
    parameter int MIN_YELLOW  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_src,
    output logic       flash_req,
    output logic [7:0] cycle_count
);
    localparam int NUM_LAMPS = 4;
    localparam logic [7:0] STALL_HIT = 8'(STALL_LIMIT - 1);

    logic [NUM_LAMPS-1:0][2:0] w_cur;
    logic [NUM_LAMPS-1:0][2:0] r_prev;
    logic                      r_prev_valid;
    logic [7:0]                r_stall;
    logic                      r_fault;
    logic [2:0]                r_code;
    logic [1:0]                r_src;
    logic [7:0]                r_cycles;

    logic [NUM_LAMPS-1:0] w_enc_bad;
    logic [NUM_LAMPS-1:0] w_non_red;
    logic [NUM_LAMPS-1:0] w_seq_bad;
    logic [NUM_LAMPS-1:0] w_short_y;
    logic [NUM_LAMPS-1:0] w_y2r;
    logic                 w_changed;
    logic                 w_stall_hit;
    logic                 w_conf_s;
    logic                 w_conf_mt;
    logic                 w_viol;
    logic [2:0]           w_code;
    logic [1:0]           w_src;

    assign w_cur = {light_S, light_MT, light_M2, light_M1};

    generate
        for (genvar g = 0; g < NUM_LAMPS; g++) begin : g_lamp
            tlm_lamp_chk #(.MIN_YELLOW(MIN_YELLOW)) u_lamp (
                .clk         (clk),
                .rst         (rst),
                .i_cur       (w_cur[g]),
                .i_prev      (r_prev[g]),
                .i_prev_valid(r_prev_valid),
                .o_enc_bad   (w_enc_bad[g]),
                .o_non_red   (w_non_red[g]),
                .o_seq_bad   (w_seq_bad[g]),
                .o_short_y   (w_short_y[g]),
                .o_y2r       (w_y2r[g])
            );
        end
    endgenerate

    function automatic logic [1:0] f_lowest(input logic [NUM_LAMPS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_LAMPS - 1; i >= 0; i--)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    assign w_changed   = (w_cur != r_prev);
    // Fires only on the transition into the limit; the saturated count stays silent
    assign w_stall_hit = r_prev_valid && !w_changed && (r_stall == STALL_HIT);
    assign w_conf_s    = w_non_red[3] && (w_non_red[0] || w_non_red[1] || w_non_red[2]);
    assign w_conf_mt   = w_non_red[1] && w_non_red[2];

    always_comb begin
        w_viol = 1'b1;
        w_code = 3'd0;
        w_src  = 2'd0;
        if (|w_enc_bad) begin
            w_code = 3'd1;
            w_src  = f_lowest(w_enc_bad);
        end else if (w_conf_s) begin
            w_code = 3'd2;
            w_src  = 2'd3;
        end else if (w_conf_mt) begin
            w_code = 3'd2;
            w_src  = 2'd2;
        end else if (|w_seq_bad) begin
            w_code = 3'd3;
            w_src  = f_lowest(w_seq_bad);
        end else if (|w_short_y) begin
            w_code = 3'd4;
            w_src  = f_lowest(w_short_y);
        end else if (w_stall_hit) begin
            w_code = 3'd5;
            w_src  = 2'd0;
        end else begin
            w_viol = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_stall      <= 8'd0;
            r_fault      <= 1'b0;
            r_code       <= 3'd0;
            r_src        <= 2'd0;
            r_cycles     <= 8'd0;
        end else begin
            r_prev       <= w_cur;
            r_prev_valid <= 1'b1;

            if (!r_prev_valid || w_changed)
                r_stall <= 8'd0;
            else if (r_stall != 8'hFF)
                r_stall <= r_stall + 8'd1;

            // A clear in the same cycle as a new violation re-latches that violation
            if (fault_clr) begin
                r_fault <= w_viol;
                r_code  <= w_code;
                r_src   <= w_src;
            end else if (!r_fault && w_viol) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
                r_src   <= w_src;
            end

            if (w_y2r[3])
                r_cycles <= r_cycles + 8'd1;
        end
    end

    assign fault       = r_fault;
    assign flash_req   = r_fault;
    assign fault_code  = r_code;
    assign fault_src   = r_src;
    assign cycle_count = r_cycles;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: reset, legal sequencing, each fault class,
// priority, clear semantics, stall saturation and cycle counter wrap.
module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault_clr;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_src;
    logic       flash_req;
    logic [7:0] cycle_count;
    logic [6:0] st;

    int checks   = 0;
    int failures = 0;

    traffic_light_monitor #(.STALL_LIMIT(12), .MIN_YELLOW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_src  (fault_src),
        .flash_req  (flash_req),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // {fault, code, src, flash_req}
    assign st = {fault, fault_code, fault_src, flash_req};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m1, m2, mt, s);
        light_M1 = m1;
        light_M2 = m2;
        light_MT = mt;
        light_S  = s;
    endtask

    task automatic phase(input logic [2:0] m1, m2, mt, s, input int n);
        drive(m1, m2, mt, s);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_cycle();
        phase(G, G, R, R, 8);
        phase(G, Y, R, R, 3);
        phase(G, R, G, R, 6);
        phase(Y, R, Y, R, 3);
        phase(R, R, R, G, 4);
        phase(R, R, R, Y, 3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fault_clr = 1'b0;
        drive(3'b111, 3'b011, G, G);
        step();
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL reset_status got=%b exp=%b", st, 7'b0);
        end
        checks++;
        if (cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", cycle_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_legal_sequence();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            checks++;
            if (st !== 7'b0) begin
                failures++;
                $display("FAIL legal_cycle%0d got=%b exp=%b", c, st, 7'b0);
            end
        end
        phase(G, G, R, R, 2);
        checks++;
        if (cycle_count !== 8'd3) begin
            failures++;
            $display("FAIL legal_count got=%0d exp=3", cycle_count);
        end
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL legal_final got=%b exp=%b", st, 7'b0);
        end
    endtask

    task automatic test_reset_mid_fault();
        drive(R, G, R, R);
        step();
        checks++;
        if (st !== {1'b1, 3'd3, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL midfault_latch got=%b exp=%b", st, {1'b1, 3'd3, 2'd0, 1'b1});
        end
        checks++;
        if (cycle_count !== 8'd3) begin
            failures++;
            $display("FAIL midfault_count got=%0d exp=3", cycle_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL midreset_status got=%b exp=%b", st, 7'b0);
        end
        checks++;
        if (cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL midreset_count got=%0d exp=0", cycle_count);
        end
    endtask

    task automatic test_encoding();
        do_reset();
        drive(R, 3'b011, R, R);
        step();
        checks++;
        if (st !== {1'b1, 3'd1, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL enc_latch got=%b exp=%b", st, {1'b1, 3'd1, 2'd1, 1'b1});
        end
        phase(R, G, R, R, 3);
        checks++;
        if (st !== {1'b1, 3'd1, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL enc_hold got=%b exp=%b", st, {1'b1, 3'd1, 2'd1, 1'b1});
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(G, R, 3'b101, G);
        step();
        checks++;
        if (st !== {1'b1, 3'd1, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL prio_enc got=%b exp=%b", st, {1'b1, 3'd1, 2'd2, 1'b1});
        end
        fault_clr = 1'b1;
        drive(G, R, R, G);
        step();
        fault_clr = 1'b0;
        checks++;
        if (st !== {1'b1, 3'd2, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL prio_conflict_clr got=%b exp=%b", st, {1'b1, 3'd2, 2'd3, 1'b1});
        end
        do_reset();
        drive(R, G, G, R);
        step();
        checks++;
        if (st !== {1'b1, 3'd2, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL conflict_m2mt got=%b exp=%b", st, {1'b1, 3'd2, 2'd2, 1'b1});
        end
    endtask

    task automatic test_sequence();
        do_reset();
        phase(G, R, R, R, 2);
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL seq_pre got=%b exp=%b", st, 7'b0);
        end
        phase(R, R, R, R, 1);
        checks++;
        if (st !== {1'b1, 3'd3, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL seq_g2r got=%b exp=%b", st, {1'b1, 3'd3, 2'd0, 1'b1});
        end
    endtask

    task automatic test_short_yellow();
        do_reset();
        phase(R, G, R, R, 2);
        phase(R, Y, R, R, 2);
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL shorty_pre got=%b exp=%b", st, 7'b0);
        end
        phase(R, R, R, R, 1);
        checks++;
        if (st !== {1'b1, 3'd4, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL shorty_latch got=%b exp=%b", st, {1'b1, 3'd4, 2'd1, 1'b1});
        end
        do_reset();
        phase(R, G, R, R, 1);
        phase(R, Y, R, R, 3);
        phase(R, R, R, R, 1);
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL shorty_exact_min got=%b exp=%b", st, 7'b0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        phase(R, R, R, R, 12);
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL stall_11 got=%b exp=%b", st, 7'b0);
        end
        step();
        checks++;
        if (st !== {1'b1, 3'd5, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL stall_12 got=%b exp=%b", st, {1'b1, 3'd5, 2'd0, 1'b1});
        end
        fault_clr = 1'b1;
        drive(G, R, R, R);
        step();
        fault_clr = 1'b0;
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL stall_clr_change got=%b exp=%b", st, 7'b0);
        end
        do_reset();
        phase(R, R, R, R, 13);
        checks++;
        if (st !== {1'b1, 3'd5, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL stall_again got=%b exp=%b", st, {1'b1, 3'd5, 2'd0, 1'b1});
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL stall_clr_held got=%b exp=%b", st, 7'b0);
        end
        repeat (15) step();
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL stall_no_repeat got=%b exp=%b", st, 7'b0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        phase(R, R, R, R, 1);
        for (int k = 0; k < 255; k++) begin
            phase(R, R, R, G, 1);
            phase(R, R, R, Y, 3);
            phase(R, R, R, R, 1);
        end
        checks++;
        if (cycle_count !== 8'd255) begin
            failures++;
            $display("FAIL wrap_255 got=%0d exp=255", cycle_count);
        end
        checks++;
        if (st !== 7'b0) begin
            failures++;
            $display("FAIL wrap_status got=%b exp=%b", st, 7'b0);
        end
        phase(R, R, R, G, 1);
        phase(R, R, R, Y, 3);
        phase(R, R, R, R, 1);
        checks++;
        if (cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_0 got=%0d exp=0", cycle_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        fault_clr = 1'b0;
        drive(R, R, R, R);
        test_reset();
        test_legal_sequence();
        test_reset_mid_fault();
        test_encoding();
        test_priority();
        test_sequence();
        test_short_yellow();
        test_stall();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent conflict/sequence monitor on the consuming end of the four-approach light bus (M1, M2, MT, S) driven by the three-road traffic light controller. It samples the 3-bit lamp vectors every clock and checks encoding, conflicting greens, lamp sequence, yellow dwell and stall. On the first violation it latches a fault code and source and raises a flash request for the cabinet's failsafe logic. It also counts completed signal cycles for status readout.

## Interface
- STALL_LIMIT, 12: consecutive cycles with no change on any lamp bit before a stall fault (legal 2..255).
- MIN_YELLOW, 3: minimum sampled cycles a lamp stays yellow before going red (legal 1..15).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- light_M1  input  3  main road 1 lamps; 100 red, 010 yellow, 001 green.
- light_M2  input  3  main road 2 lamps, same encoding.
- light_MT  input  3  main road turn lamps, same encoding.
- light_S  input  3  side road lamps, same encoding.
- fault_clr  input  1  clears latched fault (level, sampled each edge).
- fault  output  1  sticky fault flag.
- fault_code  output  3  0 none, 1 encoding, 2 conflict, 3 sequence, 4 short yellow, 5 stall.
- fault_src  output  2  offending lamp: 0 M1, 1 M2, 2 MT, 3 S.
- flash_req  output  1  equals fault; request all-red flash.
- cycle_count  output  8  completed signal cycles, wraps 255 -> 0.

## Operation
- Registered state: prev copy of all 12 lamp bits, prev_valid, per-lamp yellow dwell counter (4 bits, saturating at 15), stall counter (8 bits), fault/code/src, cycle_count.
- Encoding check: any lamp not exactly 100/010/001 -> code 1, src = that lamp.
- Conflict check: pair both non-red for pairs (M1,S), (M2,S), (MT,S), (M2,MT) -> code 2, src = higher-index lamp of the pair (S or MT).
- Sequence check (only when prev_valid): legal changes green->yellow, yellow->red, red->green; any other change (green->red, red->yellow, yellow->green) -> code 3.
- Yellow check: on legal yellow->red, if that lamp's dwell count < MIN_YELLOW -> code 4. Dwell counter clears on entering yellow, increments each cycle yellow is sampled.
- Stall: stall counter clears when current 12 bits differ from prev, else increments; reaching STALL_LIMIT -> code 5, src = 0. Counter saturates; no repeat fault while held.
- Priority when several violations in one cycle: code 1 > 2 > 3 > 4 > 5; within a code, lowest src index wins (conflict: first listed pair).
- Checks 3/4 are skipped for a lamp whose current or prev value failed encoding.
- First fault wins: while fault=1, new violations do not alter code/src.
- fault_clr=1 with no violation this cycle: fault, code, src -> 0. Violation in the same cycle as fault_clr: new fault latched (violation wins).
- cycle_count increments on legal S yellow->red, independent of fault state.
- prev always updates with the current sample; prev_valid sets after the first sample following reset.

## Timing
- Reset (rst=1 at edge): fault 0, fault_code 0, fault_src 0, flash_req 0, cycle_count 0, prev_valid 0, all counters 0. Reset mid-fault clears everything in that edge.
- Latency: violation present on inputs before edge N -> fault outputs valid after edge N (one cycle).
- First sample after reset: encoding/conflict checks active; sequence/yellow checks inactive (prev_valid=0); stall counter starts from 0.
- Stall fault asserts after edge where the STALL_LIMIT-th unchanged sample is taken.
- Outputs are registered only; no combinational input-to-output path.

## Test plan
- Drive legal controller sequence (S1 8, S2 3, S3 6, S4 3, S5 4, S6 3 cycles) for 3 full cycles -> fault stays 0, cycle_count = 3.
- After reset, M2 = 011 for one cycle -> next cycle fault=1, code=1, src=1, flash_req=1; held after M2 returns to 001.
- M1=001, S=001 simultaneously with MT=101 -> code=1, src=2 (encoding beats conflict); repeat with MT=100 after clear -> code=2, src=3.
- M1 001 -> 100 directly -> code=3, src=0; M2 yellow 2 cycles then red with MIN_YELLOW=3 -> code=4, src=1.
- Hold all lamps constant 12 cycles -> fault at 12th sample, code=5, src=0; assert fault_clr with lamps changing -> fault 0 next cycle.
- Latch a fault, assert rst mid-run -> all outputs 0 next cycle; cycle_count at 255 plus one S yellow->red -> 0.
